// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the keypad time-entry block.
// Optional feature macro: KEYPAD_AUTO_COMMIT_EN (used in keypad_time_entry).
package keypad_pkg;

   typedef logic [3:0] key_code_t;   // {row[1:0], col[1:0]}

   localparam key_code_t KEY_STAR = 4'hC;
   localparam key_code_t KEY_0    = 4'hD;
   localparam key_code_t KEY_HASH = 4'hE;

   localparam logic [6:0] MAX_HOUR = 7'd23;
   localparam logic [6:0] MAX_MIN  = 7'd59;

   typedef enum logic [2:0] {
      E0   = 3'd0,
      E1   = 3'd1,
      E2   = 3'd2,
      E3   = 3'd3,
      FULL = 3'd4
   } entry_state_t;

   typedef struct packed {
      logic       is_digit;
      logic [3:0] value;
   } digit_t;

   // Map a key code to its decimal digit; letters, '*' and '#' are not digits.
   function automatic digit_t key_to_digit(input key_code_t code);
      digit_t d;
      d.is_digit = 1'b1;
      d.value    = 4'd0;
      case (code)
         4'h0:    d.value = 4'd1;
         4'h1:    d.value = 4'd2;
         4'h2:    d.value = 4'd3;
         4'h4:    d.value = 4'd4;
         4'h5:    d.value = 4'd5;
         4'h6:    d.value = 4'd6;
         4'h8:    d.value = 4'd7;
         4'h9:    d.value = 4'd8;
         4'hA:    d.value = 4'd9;
         KEY_0:   d.value = 4'd0;
         default: d.is_digit = 1'b0;
      endcase
      return d;
   endfunction

   // Two BCD digits to binary, kept at 7 bits so out-of-range values survive the check.
   function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
      return 7'(tens) * 7'd10 + 7'(ones);
   endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Column scanner, row synchronizer, per-frame key decode and press debouncer.
// Emits a single-cycle press_valid with press_code once per debounced press.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV        = 16'd50000,
   parameter int          DEBOUNCE_FRAMES = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   output logic [3:0] col_out,
   input  logic [3:0] row_in,
   output logic      press_valid,
   output key_code_t press_code
);

   localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

   logic [3:0]  row_meta, row_sync;
   logic [15:0] div_cnt;
   logic [1:0]  col;
   logic        dwell_end;
   logic [1:0]  acc_cnt;      // keys seen so far this frame, saturating at 2
   key_code_t   acc_code;
   logic [2:0]  n_rows, sum;
   logic [1:0]  hit_row, sum_sat;
   key_code_t   code_new;
   logic        frame_end, frame_key, same;
   logic        prev_key, pressed;
   key_code_t   prev_code;
   logic [3:0]  run, run_next;

   assign dwell_end = (div_cnt == SCAN_DIV - 16'd1);
   assign frame_end = dwell_end && (col == 2'd3);
   assign col_out   = ~(4'b0001 << col);

   // Two-flop synchronizer for the asynchronous row lines (idle high).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   // Dwell counter and column index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
         col     <= '0;
      end else if (dwell_end) begin
         div_cnt <= '0;
         col     <= col + 2'd1;
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   // Fold this column's rows into the frame tally and compare against the last frame.
   always_comb begin
      n_rows  = '0;
      hit_row = '0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_sync[r]) begin
            n_rows  = n_rows + 3'd1;
            hit_row = 2'(r);
         end
      end
      sum       = {1'b0, acc_cnt} + n_rows;
      sum_sat   = (sum > 3'd2) ? 2'd2 : sum[1:0];
      code_new  = (acc_cnt == 2'd0 && n_rows == 3'd1) ? {hit_row, col} : acc_code;
      frame_key = (sum_sat == 2'd1);
      same      = (frame_key == prev_key) && (!frame_key || code_new == prev_code);
      run_next  = same ? ((run == 4'hF) ? run : run + 4'd1) : 4'd1;
   end

   // Frame accumulation and the released/pressed debounce state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_cnt     <= '0;
         acc_code    <= '0;
         prev_key    <= 1'b0;
         prev_code   <= '0;
         run         <= '0;
         pressed     <= 1'b0;
         press_valid <= 1'b0;
         press_code  <= '0;
      end else begin
         press_valid <= 1'b0;
         if (frame_end) begin
            acc_cnt   <= '0;
            acc_code  <= '0;
            prev_key  <= frame_key;
            prev_code <= code_new;
            run       <= run_next;
            if (!pressed && frame_key && run_next >= DF) begin
               pressed     <= 1'b1;
               press_valid <= 1'b1;
               press_code  <= code_new;
            end else if (pressed && !frame_key && run_next >= DF) begin
               pressed <= 1'b0;
            end
         end else if (dwell_end) begin
            acc_cnt  <= sum_sat;
            acc_code <= code_new;
         end
      end
   end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad HHMM entry: collects four digits, validates and commits binary hour/min.
// Optional feature macro: KEYPAD_AUTO_COMMIT_EN -- commit on the 4th digit, '#' always errors.
module keypad_time_entry
   import keypad_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV        = 16'd50000,
   parameter int          DEBOUNCE_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  col_out,
   input  logic [3:0]  row_in,
   output logic [4:0]  hour,
   output logic [5:0]  min,
   output logic        time_valid,
   output logic        entry_err,
   output logic [15:0] digits,
   output logic [2:0]  digit_cnt
);

   logic         press_valid;
   key_code_t    press_code;
   entry_state_t state, state_n;
   logic [15:0]  digits_n, shifted, cand;
   logic [4:0]   hour_n;
   logic [5:0]   min_n;
   logic         tv_n, err_n, commit_ok;
   logic [6:0]   ch7, cm7;
   digit_t       dig;

   keypad_scan_debounce #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_scan (
      .clk         (clk),
      .rst_n       (rst_n),
      .col_out     (col_out),
      .row_in      (row_in),
      .press_valid (press_valid),
      .press_code  (press_code)
   );

   assign digit_cnt = state;

   // Entry FSM: digit shifting, clear, error and commit decisions.
   always_comb begin
      state_n  = state;
      digits_n = digits;
      hour_n   = hour;
      min_n    = min;
      tv_n     = 1'b0;
      err_n    = 1'b0;
      dig      = key_to_digit(press_code);
      shifted  = {digits[11:0], dig.value};
`ifdef KEYPAD_AUTO_COMMIT_EN
      cand     = shifted;   // the digit being entered completes the entry
`else
      cand     = digits;
`endif
      ch7       = bcd2bin(cand[15:12], cand[11:8]);
      cm7       = bcd2bin(cand[7:4], cand[3:0]);
      commit_ok = (ch7 <= MAX_HOUR) && (cm7 <= MAX_MIN);

      if (press_valid) begin
         if (press_code == KEY_STAR) begin
            digits_n = '0;
            state_n  = E0;
         end else if (press_code == KEY_HASH) begin
            digits_n = '0;
            state_n  = E0;
`ifdef KEYPAD_AUTO_COMMIT_EN
            err_n    = 1'b1;
`else
            if (state == FULL) begin
               if (commit_ok) begin
                  hour_n = ch7[4:0];
                  min_n  = cm7[5:0];
                  tv_n   = 1'b1;
               end else begin
                  err_n  = 1'b1;
               end
            end else begin
               err_n = 1'b1;
            end
`endif
         end else if (dig.is_digit) begin
            case (state)
               E0: begin digits_n = shifted; state_n = E1; end
               E1: begin digits_n = shifted; state_n = E2; end
               E2: begin digits_n = shifted; state_n = E3; end
               E3: begin
`ifdef KEYPAD_AUTO_COMMIT_EN
                  digits_n = '0;
                  state_n  = E0;
                  if (commit_ok) begin
                     hour_n = ch7[4:0];
                     min_n  = cm7[5:0];
                     tv_n   = 1'b1;
                  end else begin
                     err_n  = 1'b1;
                  end
`else
                  digits_n = shifted;
                  state_n  = FULL;
`endif
               end
               default: ;   // FULL: extra digits are dropped silently
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= E0;
         digits     <= '0;
         hour       <= '0;
         min        <= '0;
         time_valid <= 1'b0;
         entry_err  <= 1'b0;
      end else begin
         state      <= state_n;
         digits     <= digits_n;
         hour       <= hour_n;
         min        <= min_n;
         time_valid <= tv_n;
         entry_err  <= err_n;
      end
   end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry (SCAN_DIV=4, DEBOUNCE_FRAMES=2).
// Table-driven key entries plus hand sequences for bounce, ghosting, long hold and reset.
module tb_keypad_time_entry;

   logic        clk, rst_n;
   logic [3:0]  col_out, row_in;
   logic [4:0]  hour;
   logic [5:0]  min;
   logic        time_valid, entry_err;
   logic [15:0] digits;
   logic [2:0]  digit_cnt;
   logic [15:0] key_mask;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  key;
      logic [15:0] dig;
      logic [2:0]  cnt;
      logic [1:0]  evt;   // 0 none, 1 time_valid, 2 entry_err
      logic [4:0]  h;
      logic [5:0]  m;
   } vec_t;

   typedef struct {
      logic       err;
      logic [4:0] h;
      logic [5:0] m;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];

   keypad_time_entry #(.SCAN_DIV(16'd4), .DEBOUNCE_FRAMES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .col_out    (col_out),
      .row_in     (row_in),
      .hour       (hour),
      .min        (min),
      .time_valid (time_valid),
      .entry_err  (entry_err),
      .digits     (digits),
      .digit_cnt  (digit_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Keypad matrix model: a pressed key pulls its row low while its column is driven.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_in[r] = 1'b1;
         for (int c = 0; c < 4; c++)
            if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] key, input logic [15:0] dig, input logic [2:0] cnt,
                      input logic [1:0] evt, input logic [4:0] h, input logic [5:0] m);
      tbl.push_back('{key, dig, cnt, evt, h, m});
   endtask

   task automatic hold(input logic [15:0] mask, input int on_cyc, input int off_cyc);
      key_mask = mask;
      repeat (on_cyc) @(posedge clk);
      #1 key_mask = '0;
      repeat (off_cyc) @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every output pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (time_valid || entry_err)) begin
         check("pulse_exclusive", 32'(time_valid & entry_err), 32'd0);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got tv=%0b err=%0b expected no pulse", time_valid, entry_err);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("evt_is_err", 32'(entry_err), 32'(e.err));
            check("evt_hour", 32'(hour), 32'(e.h));
            check("evt_min", 32'(min), 32'(e.m));
         end
      end
   end

   localparam logic [3:0] K1 = 4'h0, K2 = 4'h1, K3 = 4'h2, K4 = 4'h4, K5 = 4'h5,
                          K7 = 4'h8, K9 = 4'hA, K0 = 4'hD, KS = 4'hC, KH = 4'hE;

   initial begin
      logic [3:0] col_seq [4];
      col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;
      key_mask = '0;
      rst_n    = 1'b0;

`ifdef KEYPAD_AUTO_COMMIT_EN
      add(K2, 16'h0002, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K3, 16'h0023, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K5, 16'h0235, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K9, 16'h0000, 3'd0, 2'd1, 5'd23, 6'd59);
      add(K1, 16'h0001, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K2, 16'h0012, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K3, 16'h0123, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K4, 16'h0000, 3'd0, 2'd1, 5'd12, 6'd34);
      add(K2, 16'h0002, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K4, 16'h0024, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K0, 16'h0240, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K0, 16'h0000, 3'd0, 2'd2, 5'd12, 6'd34);
      add(K0, 16'h0000, 3'd1, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd2, 5'd12, 6'd34);
`else
      add(K1, 16'h0001, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K2, 16'h0012, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K3, 16'h0123, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K4, 16'h1234, 3'd4, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd1, 5'd12, 6'd34);
      add(K2, 16'h0002, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K5, 16'h0025, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K0, 16'h0250, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K0, 16'h2500, 3'd4, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd2, 5'd12, 6'd34);
      add(K0, 16'h0000, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K9, 16'h0009, 3'd2, 2'd0, 5'd0,  6'd0);
      add(KS, 16'h0000, 3'd0, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd2, 5'd12, 6'd34);
      add(K1, 16'h0001, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K9, 16'h0019, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K5, 16'h0195, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K9, 16'h1959, 3'd4, 2'd0, 5'd0,  6'd0);
      add(K7, 16'h1959, 3'd4, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd1, 5'd19, 6'd59);
      add(K2, 16'h0002, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K3, 16'h0023, 3'd2, 2'd0, 5'd0,  6'd0);
      add(6,  16'h0236, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K0, 16'h2360, 3'd4, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd2, 5'd19, 6'd59);
      add(K2, 16'h0002, 3'd1, 2'd0, 5'd0,  6'd0);
      add(K3, 16'h0023, 3'd2, 2'd0, 5'd0,  6'd0);
      add(K5, 16'h0235, 3'd3, 2'd0, 5'd0,  6'd0);
      add(K9, 16'h2359, 3'd4, 2'd0, 5'd0,  6'd0);
      add(KH, 16'h0000, 3'd0, 2'd1, 5'd23, 6'd59);
`endif

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_col_out", 32'(col_out), 32'(4'b1110));
      check("rst_hour", 32'(hour), 32'd0);
      check("rst_min", 32'(min), 32'd0);
      check("rst_tv", 32'(time_valid), 32'd0);
      check("rst_err", 32'(entry_err), 32'd0);
      check("rst_digits", 32'(digits), 32'd0);
      check("rst_cnt", 32'(digit_cnt), 32'd0);
      rst_n = 1'b1;

      // Column stepping: one column every 4 clocks
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk);
         #1 check($sformatf("col_step%0d", n), 32'(col_out), 32'(col_seq[(n/4)%4]));
      end

      // Table-driven key entries: 3 frames held, 3 frames released
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].evt != 2'd0) sb.push_back('{tbl[i].evt == 2'd2, tbl[i].h, tbl[i].m});
         hold(16'h0001 << tbl[i].key, 48, 48);
         check($sformatf("digits[%0d]", i), 32'(digits), 32'(tbl[i].dig));
         check($sformatf("cnt[%0d]", i), 32'(digit_cnt), 32'(tbl[i].cnt));
         check($sformatf("sb_drain[%0d]", i), 32'(sb.size()), 32'd0);
      end

      // Bounce: key '7' on for 5 of every 32 clocks -> never two consecutive frames
      for (int b = 0; b < 8; b++) hold(16'h0001 << K7, 5, 27);
      repeat (48) @(posedge clk);
      #1;
      check("bounce_cnt", 32'(digit_cnt), 32'd0);
      check("bounce_digits", 32'(digits), 32'd0);

      // Ghosting: '1' and '5' together -> no event
      hold((16'h0001 << K1) | (16'h0001 << K5), 160, 48);
      check("ghost_cnt", 32'(digit_cnt), 32'd0);
      check("ghost_digits", 32'(digits), 32'd0);

      // Long hold of '5' for 10 frames -> exactly one digit
      hold(16'h0001 << K5, 160, 48);
      check("hold_cnt", 32'(digit_cnt), 32'd1);
      check("hold_digits", 32'(digits), 32'h0005);

      // Reset mid-entry discards the partial entry
      hold(16'h0001 << K1, 48, 48);
      hold(16'h0001 << K2, 48, 48);
      check("pre_rst_cnt", 32'(digit_cnt), 32'd3);
      check("pre_rst_digits", 32'(digits), 32'h0512);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_cnt", 32'(digit_cnt), 32'd0);
      check("mid_rst_digits", 32'(digits), 32'd0);
      check("mid_rst_hour", 32'(hour), 32'd0);
      check("mid_rst_min", 32'(min), 32'd0);
      check("mid_rst_col", 32'(col_out), 32'(4'b1110));
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
Reads a 4x4 matrix keypad by driving columns one at a time and sampling the rows. Debounces key presses and collects a four-digit HHMM entry. On commit it checks the entry and converts it to binary hour/min for the clock counters. It is the input-side partner of the display digit scanner: that block turns hour/min into digits, this block turns digits back into hour/min.

Parameters:
SCAN_DIV, 16'd50000, clk cycles each column is driven (dwell); minimum 2
DEBOUNCE_FRAMES, 4, consecutive full 4-column frames a key state must hold before it is accepted; range 1..15

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
col_out  output  4  keypad column drive, one-cold (active-low)
row_in  input  4  keypad rows, active-low, pulled up, asynchronous
hour  output  5  committed hour, binary 0..23
min  output  6  committed minute, binary 0..59
time_valid  output  1  one-cycle pulse when hour/min update
entry_err  output  1  one-cycle pulse on a rejected commit or a misplaced '#'
digits  output  16  BCD echo of the entry {H1,H0,M1,M0}, for display
digit_cnt  output  3  digits entered so far, 0..4

Behaviour:
- Reset (rst_n low at clk edge): col_out=4'b1110, hour=0, min=0, time_valid=0, entry_err=0, digits=0, digit_cnt=0.
- Reset also clears the scan counter, column index, debounce state and the entry FSM (returns to E0). Reset mid-entry discards the partial entry.
- row_in passes through a 2-flop synchronizer before use.
- Column scan:
  - col index c cycles 0..3 and advances every SCAN_DIV clocks.
  - col_out = ~(4'b0001 << c).
  - Rows are sampled on the last dwell cycle of each column.
- Frame: one pass over all 4 columns.
  - Frame code = {row,col} when exactly one key is seen in the whole frame.
  - Otherwise the frame is NONE: zero keys, or two or more keys (ghosting is rejected).
- Debounce:
  - A press event fires once, when the same code has been seen for DEBOUNCE_FRAMES consecutive frames while the block is in the released state.
  - The block then stays in the pressed state until NONE has been seen for DEBOUNCE_FRAMES consecutive frames.
  - Holding a key never repeats. A code change while pressed produces no event.
- Key map (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - A-D are ignored.
- Entry FSM states E0, E1, E2, E3, FULL; digit_cnt = 0..4 to match.
  - Digit in E0..E3: shift it into digits (H1 first), advance one state.
  - Digit in FULL: ignored, no error.
  - '*' in any state: digits=0, go to E0.
  - '#' in E0..E3: entry_err pulse, digits cleared, go to E0.
  - '#' in FULL: commit.
- Commit:
  - Valid when H1*10+H0 <= 23 and M1*10+M0 <= 59.
  - Valid: on the next clk, hour/min are loaded, time_valid pulses for 1 cycle, digits cleared, go to E0.
  - Invalid: entry_err pulses for 1 cycle, hour/min unchanged, digits cleared, go to E0.
- Latency: press event to output register update is 1 clk.
- Width rules: BCD to binary is tens*10+ones computed at 7 bits, then truncated to 5 bits (hour) and 6 bits (min) only after the range check.
- time_valid and entry_err are never high in the same cycle.

Optional Feature:
KEYPAD_AUTO_COMMIT_EN
- Defined: entering the 4th digit (E3 to FULL) triggers the commit check in the same event. No '#' is needed. '#' in any state gives entry_err. The FULL state is passed through and is never held.
- Undefined: behaviour exactly as above ('#' commits).

Decomposition:
- Package keypad_pkg holds:
  - key code typedef (4 bits)
  - key-map constants KEY_STAR=4'hC, KEY_0=4'hD, KEY_HASH=4'hE (codes {row,col})
  - the digit lookup function
  - the entry-state enum
  - constants MAX_HOUR=23, MAX_MIN=59
- One sub-module, keypad_scan_debounce: column drive, synchronizer, frame decode and debounce. It outputs press_valid (1-cycle pulse) and press_code.
- The top level holds the entry FSM, BCD checking and output registers.

Test Plan:
Bench settings: SCAN_DIV=4, DEBOUNCE_FRAMES=2.
- Reset: hold rst_n=0 for 3 clk -> col_out=1110, hour=0, min=0, digits=0, digit_cnt=0; after release col_out steps 1110, 1101, 1011, 0111 every 4 clk.
- Press 1,2,3,4 then '#' (each key held for 3 frames, released for 3 frames) -> digits=16'h1234, digit_cnt=4 before '#'; then hour=12, min=34, one time_valid pulse, digit_cnt=0.
- Enter 2,5,0,0 then '#' -> entry_err pulse, hour/min keep their previous values, digits=0.
- Enter 0,9 then '*' -> digits=0, digit_cnt=0; then '#' -> entry_err pulse.
- Bounce and ghosting: key toggling faster than one frame -> no event; keys 1 and 5 held together -> no event; a single key held for 10 frames -> exactly one event.
- Reset asserted after 3 digits -> digit_cnt=0, digits=0. With KEYPAD_AUTO_COMMIT_EN defined: entering 2,3,5,9 -> hour=23, min=59, time_valid pulses with no '#'.
